wb_stage_v2: RTL and testbench

Parametrised write-back stage for the in-order RISC-V pipeline, sitting between the memory stage and the register-file write port. It registers one retiring instruction per cycle and selects its result from four sources (ALU, load, PC+4, CSR). Loads get byte/half/word/double extraction with sign or zero extension, and misaligned loads are suppressed. The stage also keeps a retired-instruction counter.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_stage_v2_if.sv | 36 +++
 rtl/wb_stage_v2_load_align.sv | 56 +++++
 rtl/wb_stage_v2.sv | 94 +++++++++
 tb/tb_wb_stage_v2.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

  // Result source selected for the retiring instruction.
  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_CSR  = 2'd3
  } wb_sel_t;

  // Load funct3 encodings; 3'b111 is reserved.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Field positions inside the 32-bit instruction word.
  localparam int RD_LSB = 7;
  localparam int F3_LSB = 12;

endpackage

// File: rtl/wb_stage_v2_if.sv
// Bundle of memory-stage inputs and register-file outputs of the write-back stage.
// Handshake: an instruction is taken on every rising edge where i_valid=1 and
// i_flush=0; there is no ready/backpressure, the stage always accepts.
interface wb_stage_v2_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            i_valid;
  logic            i_flush;
  logic [31:0]     i_instruction;
  logic            i_reg_write;
  logic [1:0]      i_wb_sel;
  logic [XLEN-1:0] i_alu_result;
  logic [XLEN-1:0] i_mem_data;
  logic [XLEN-1:0] i_pc_plus4;
  logic [XLEN-1:0] i_csr_data;
  logic [AW-1:0]   o_rd_index;
  logic [XLEN-1:0] o_rd_data;
  logic            o_rd_we;
  logic            o_load_fault;
  logic [63:0]     o_instret;

  // Memory-stage side: drives the instruction, observes the write port.
  modport master (
    output i_valid, i_flush, i_instruction, i_reg_write, i_wb_sel,
           i_alu_result, i_mem_data, i_pc_plus4, i_csr_data,
    input  o_rd_index, o_rd_data, o_rd_we, o_load_fault, o_instret
  );

  // Write-back stage side.
  modport slave (
    input  i_valid, i_flush, i_instruction, i_reg_write, i_wb_sel,
           i_alu_result, i_mem_data, i_pc_plus4, i_csr_data,
    output o_rd_index, o_rd_data, o_rd_we, o_load_fault, o_instret
  );
endinterface

// File: rtl/wb_stage_v2_load_align.sv
// Combinational load extraction: shifts the addressed lane down, applies
// sign/zero extension and flags misaligned or unsupported loads.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OW   = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [OW-1:0]   i_off,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data,
  output logic            o_fault
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_ext;
  logic            w_fault;

  assign w_shifted = i_word >> {i_off, 3'b000};

  // Extend the selected lane and detect alignment / encoding faults.
  always_comb begin
    w_ext   = '0;
    w_fault = 1'b0;
    case (i_funct3)
      F3_LB:  w_ext = XLEN'($signed(w_shifted[7:0]));
      F3_LBU: w_ext = XLEN'(w_shifted[7:0]);
      F3_LH: begin
        w_ext   = XLEN'($signed(w_shifted[15:0]));
        w_fault = i_off[0];
      end
      F3_LHU: begin
        w_ext   = XLEN'(w_shifted[15:0]);
        w_fault = i_off[0];
      end
      F3_LW: begin
        w_ext   = XLEN'($signed(w_shifted[31:0]));
        w_fault = |i_off[1:0];
      end
      F3_LWU: begin
        w_ext   = XLEN'(w_shifted[31:0]);
        w_fault = (|i_off[1:0]) | (XLEN == 32);
      end
      F3_LD: begin
        w_ext   = w_shifted;
        w_fault = (|i_off) | (XLEN == 32);
      end
      default: w_fault = 1'b1;
    endcase
  end

  assign o_fault = w_fault;
  assign o_data  = w_fault ? '0 : w_ext;

endmodule

// File: rtl/wb_stage_v2.sv
// Write-back stage: registers one retiring instruction per cycle, selects its
// result, and counts retired instructions. Outputs double as the WB forward path.
module wb_stage_v2
  import wb_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic      i_clk,
  input  logic      i_rst,
  wb_stage_v2_if.slave bus
);

  localparam int OW = $clog2(XLEN/8);

  logic [AW-1:0]   r_rd_index;
  logic [XLEN-1:0] r_rd_data;
  logic            r_rd_we;
  logic            r_load_fault;
  logic [63:0]     r_instret;

  logic            w_accept;
  logic [AW-1:0]   w_rd;
  logic [2:0]      w_f3;
  wb_sel_t         w_sel;
  logic [XLEN-1:0] w_load_data;
  logic            w_align_fault;
  logic            w_fault;
  logic [XLEN-1:0] w_result;
  logic            w_unused;

  assign w_accept = bus.i_valid & ~bus.i_flush;
  assign w_rd     = bus.i_instruction[RD_LSB +: AW];
  assign w_f3     = bus.i_instruction[F3_LSB +: 3];
  assign w_sel    = wb_sel_t'(bus.i_wb_sel);
  assign w_fault  = (w_sel == WB_LOAD) & w_align_fault;
  assign w_unused = ^{bus.i_instruction[31:15], bus.i_instruction[6:0]};

  load_align #(
    .XLEN (XLEN),
    .OW   (OW)
  ) u_load_align (
    .i_word   (bus.i_mem_data),
    .i_off    (bus.i_alu_result[OW-1:0]),
    .i_funct3 (w_f3),
    .o_data   (w_load_data),
    .o_fault  (w_align_fault)
  );

  // Pick the write-back value from the selected source.
  always_comb begin
    w_result = bus.i_alu_result;
    case (w_sel)
      WB_ALU:  w_result = bus.i_alu_result;
      WB_LOAD: w_result = w_load_data;
      WB_PC4:  w_result = bus.i_pc_plus4;
      WB_CSR:  w_result = bus.i_csr_data;
      default: w_result = bus.i_alu_result;
    endcase
  end

  // Output registers and retire counter; bubbles hold index/data and drop pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_index   <= '0;
      r_rd_data    <= '0;
      r_rd_we      <= 1'b0;
      r_load_fault <= 1'b0;
      r_instret    <= '0;
    end else if (w_accept) begin
      r_rd_index <= w_rd;
      if (w_fault) begin
        r_rd_data    <= '0;
        r_rd_we      <= 1'b0;
        r_load_fault <= 1'b1;
      end else begin
        r_rd_data    <= w_result;
        r_rd_we      <= bus.i_reg_write & (w_rd != '0);
        r_load_fault <= 1'b0;
        r_instret    <= r_instret + 64'd1;
      end
    end else begin
      r_rd_we      <= 1'b0;
      r_load_fault <= 1'b0;
    end
  end

  assign bus.o_rd_index   = r_rd_index;
  assign bus.o_rd_data    = r_rd_data;
  assign bus.o_rd_we      = r_rd_we;
  assign bus.o_load_fault = r_load_fault;
  assign bus.o_instret    = r_instret;

endmodule

// File: tb/tb_wb_stage_v2.sv
// Bench for wb_stage_v2: a 64-bit and a 32-bit instance checked against a
// byte-arithmetic reference model through per-cycle expected queues.
module tb_wb_stage_v2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst64, rst32;

  wb_stage_v2_if #(.XLEN(64), .AW(5)) b64 ();
  wb_stage_v2_if #(.XLEN(32), .AW(5)) b32 ();

  wb_stage_v2 #(.XLEN(64), .AW(5)) dut (.i_clk(clk), .i_rst(rst64), .bus(b64));
  wb_stage_v2 #(.XLEN(32), .AW(5)) dut32 (.i_clk(clk), .i_rst(rst32), .bus(b32));

  int checks = 0;
  int errors = 0;

  // Scoreboards: {index, data, we, fault, instret}
  logic [134:0] exp_q[$];
  logic [102:0] exp32_q[$];
  logic [134:0] exp64, obs64;
  logic [102:0] exp32, obs32;

  // Reference-model architectural state.
  logic [4:0]  m_idx;  logic [63:0] m_data; logic [63:0] m_cnt;
  logic [4:0]  n_idx;  logic [31:0] n_data; logic [63:0] n_cnt;

  // ---------------- reference model ----------------
  function automatic void ref_load(input int xlen, input logic [63:0] addr,
                                   input logic [63:0] mem, input logic [2:0] f3,
                                   output logic [63:0] data, output logic fault);
    int size, off;
    logic [63:0] mask, v;
    size  = 1 << f3[1:0];
    off   = int'(addr % 64'(xlen / 8));
    fault = (f3 == 3'b111) || (xlen == 32 && (f3 == 3'b011 || f3 == 3'b110)) ||
            ((off % size) != 0);
    v    = mem >> (off * 8);
    mask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (size * 8)) - 64'd1);
    v    = v & mask;
    if (!f3[2] && size < 8 && v[size*8-1]) v = v | ~mask;
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    data = fault ? 64'd0 : v;
  endfunction

  function automatic void ref_result(input int xlen, input logic [1:0] sel,
                                     input logic [63:0] alu, mem, pc4, csr,
                                     input logic [2:0] f3,
                                     output logic [63:0] data, output logic fault);
    fault = 1'b0;
    case (sel)
      2'd0: data = alu;
      2'd1: ref_load(xlen, alu, mem, f3, data, fault);
      2'd2: data = pc4;
      default: data = csr;
    endcase
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [2:0] f3);
    return {17'd0, f3, rd, 7'b0000011};
  endfunction

  // ---------------- drivers ----------------
  task automatic cycle64(input logic rst, valid, flush, input logic [31:0] instr,
                         input logic we, input logic [1:0] sel,
                         input logic [63:0] alu, mem, pc4, csr);
    logic [63:0] d; logic f, we_e, f_e;
    @(negedge clk);
    rst64 = rst;
    b64.i_valid = valid; b64.i_flush = flush; b64.i_instruction = instr;
    b64.i_reg_write = we; b64.i_wb_sel = sel; b64.i_alu_result = alu;
    b64.i_mem_data = mem; b64.i_pc_plus4 = pc4; b64.i_csr_data = csr;
    we_e = 1'b0; f_e = 1'b0;
    if (rst) begin
      m_idx = '0; m_data = '0; m_cnt = '0;
    end else if (valid && !flush) begin
      ref_result(64, sel, alu, mem, pc4, csr, instr[14:12], d, f);
      m_idx = instr[11:7];
      if (f) begin
        m_data = '0; f_e = 1'b1;
      end else begin
        m_data = d; we_e = we && (instr[11:7] != 5'd0); m_cnt = m_cnt + 64'd1;
      end
    end
    exp_q.push_back({m_idx, m_data, we_e, f_e, m_cnt});
    @(posedge clk); #1;
    b64.i_valid = 1'b0; rst64 = 1'b0;
  endtask

  task automatic cycle32(input logic rst, valid, input logic [31:0] instr,
                         input logic we, input logic [1:0] sel,
                         input logic [31:0] alu, mem);
    logic [63:0] d; logic f, we_e, f_e;
    @(negedge clk);
    rst32 = rst;
    b32.i_valid = valid; b32.i_flush = 1'b0; b32.i_instruction = instr;
    b32.i_reg_write = we; b32.i_wb_sel = sel; b32.i_alu_result = alu;
    b32.i_mem_data = mem; b32.i_pc_plus4 = alu + 32'd4; b32.i_csr_data = ~alu;
    we_e = 1'b0; f_e = 1'b0;
    if (rst) begin
      n_idx = '0; n_data = '0; n_cnt = '0;
    end else if (valid) begin
      ref_result(32, sel, 64'(alu), 64'(mem), 64'(alu + 32'd4), 64'(~alu),
                 instr[14:12], d, f);
      n_idx = instr[11:7];
      if (f) begin
        n_data = '0; f_e = 1'b1;
      end else begin
        n_data = d[31:0]; we_e = we && (instr[11:7] != 5'd0); n_cnt = n_cnt + 64'd1;
      end
    end
    exp32_q.push_back({n_idx, n_data, we_e, f_e, n_cnt});
    @(posedge clk); #1;
    b32.i_valid = 1'b0; rst32 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst32 = 1'b1; n_idx = '0; n_data = '0; n_cnt = '0;
    cycle64(1'b1, 1'b1, 1'b0, mk_instr(5'd3, 3'b000), 1'b1, 2'd0, 64'h55, 0, 0, 0);
    exp64 = exp_q.pop_front();
    obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
    checks++;
    if (obs64 !== 135'd0 || obs64 !== exp64) begin
      errors++; $display("FAIL reset64: got %h exp %h", obs64, exp64);
    end
    obs32 = {b32.o_rd_index, b32.o_rd_data, b32.o_rd_we, b32.o_load_fault, b32.o_instret};
    checks++;
    if (obs32 !== 103'd0) begin
      errors++; $display("FAIL reset32: got %h exp 0", obs32);
    end
  endtask

  task automatic test_alu();
    cycle64(1'b0, 1'b1, 1'b0, mk_instr(5'd5, 3'b000), 1'b1, 2'd0, 64'h1234, 0, 0, 0);
    exp64 = exp_q.pop_front();
    obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
    checks++;
    if (obs64 !== exp64 || b64.o_rd_data !== 64'h1234 || b64.o_rd_index !== 5'd5 ||
        b64.o_rd_we !== 1'b1 || b64.o_instret !== 64'd1) begin
      errors++; $display("FAIL alu: got %h exp %h", obs64, exp64);
    end
  endtask

  task automatic test_load_ext();
    logic [63:0] want [2] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80};
    logic [2:0]  f3s  [2] = '{3'b000, 3'b100};
    for (int i = 0; i < 2; i++) begin
      cycle64(1'b0, 1'b1, 1'b0, mk_instr(5'd6, f3s[i]), 1'b1, 2'd1,
              64'h1002, 64'h0000_0000_0080_FF00, 0, 0);
      exp64 = exp_q.pop_front();
      obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
      checks++;
      if (obs64 !== exp64 || b64.o_rd_data !== want[i]) begin
        errors++; $display("FAIL load_ext%0d: got %h exp %h", i, obs64, exp64);
      end
    end
  endtask

  task automatic test_fault();
    logic [63:0] cnt0;
    cnt0 = b64.o_instret;
    cycle64(1'b0, 1'b1, 1'b0, mk_instr(5'd7, 3'b010), 1'b1, 2'd1, 64'h2002, 64'hDEAD_BEEF_CAFE_F00D, 0, 0);
    exp64 = exp_q.pop_front();
    obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
    checks++;
    if (obs64 !== exp64 || b64.o_load_fault !== 1'b1 || b64.o_rd_we !== 1'b0 ||
        b64.o_instret !== cnt0) begin
      errors++; $display("FAIL lw_misaligned: got %h exp %h", obs64, exp64);
    end
    cycle64(1'b0, 1'b1, 1'b0, mk_instr(5'd8, 3'b001), 1'b1, 2'd1, 64'h3006, 64'h7FFF_0000_1111_2222, 0, 0);
    exp64 = exp_q.pop_front();
    obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
    checks++;
    if (obs64 !== exp64 || b64.o_rd_data !== 64'h7FFF || b64.o_load_fault !== 1'b0) begin
      errors++; $display("FAIL lh_off6: got %h exp %h", obs64, exp64);
    end
  endtask

  task automatic test_x0_flush();
    logic [63:0] cnt0;
    cnt0 = b64.o_instret;
    cycle64(1'b0, 1'b1, 1'b0, mk_instr(5'd0, 3'b000), 1'b1, 2'd2, 0, 0, 64'h4444, 0);
    exp64 = exp_q.pop_front();
    obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
    checks++;
    if (obs64 !== exp64 || b64.o_rd_we !== 1'b0 || b64.o_instret !== cnt0 + 64'd1) begin
      errors++; $display("FAIL write_x0: got %h exp %h", obs64, exp64);
    end
    cycle64(1'b0, 1'b1, 1'b1, mk_instr(5'd9, 3'b000), 1'b1, 2'd3, 0, 0, 0, 64'h9999);
    exp64 = exp_q.pop_front();
    obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
    checks++;
    if (obs64 !== exp64 || b64.o_rd_we !== 1'b0 || b64.o_instret !== cnt0 + 64'd1) begin
      errors++; $display("FAIL flush: got %h exp %h", obs64, exp64);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      cycle64(1'b0, 1'b1, 1'b0, mk_instr(5'd12, 3'b000), 1'b1, 2'd0, 64'hA0 + 64'(i), 0, 0, 0);
      exp64 = exp_q.pop_front();
      obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
      checks++;
      if (obs64 !== exp64 || b64.o_rd_data !== 64'hA0 + 64'(i)) begin
        errors++; $display("FAIL back_to_back%0d: got %h exp %h", i, obs64, exp64);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle64(1'b0, 1'b1, 1'b0, mk_instr(5'd4, 3'b000), 1'b0, 2'd0, 64'h1, 0, 0, 0);
    exp64 = exp_q.pop_front();
    obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
    checks++;
    if (obs64 !== exp64 || b64.o_instret !== 64'd0) begin
      errors++; $display("FAIL instret_wrap: got %h exp %h", obs64, exp64);
    end
    cycle64(1'b0, 1'b1, 1'b0, mk_instr(5'd11, 3'b000), 1'b1, 2'd0, 64'h77, 0, 0, 0);
    void'(exp_q.pop_front());
    cycle64(1'b1, 1'b1, 1'b0, mk_instr(5'd13, 3'b000), 1'b1, 2'd0, 64'h88, 0, 0, 0);
    exp64 = exp_q.pop_front();
    obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
    checks++;
    if (obs64 !== exp64 || obs64 !== 135'd0) begin
      errors++; $display("FAIL reset_midstream: got %h exp %h", obs64, exp64);
    end
  endtask

  task automatic test_random();
    logic [4:0] rd; logic [2:0] f3;
    for (int i = 0; i < 300; i++) begin
      rd = 5'($urandom_range(0, 31));
      f3 = 3'($urandom_range(0, 7));
      cycle64(($urandom_range(0, 60) == 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 9) == 0), mk_instr(rd, f3), 1'($urandom),
              2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom});
      exp64 = exp_q.pop_front();
      obs64 = {b64.o_rd_index, b64.o_rd_data, b64.o_rd_we, b64.o_load_fault, b64.o_instret};
      checks++;
      if (obs64 !== exp64) begin
        errors++; $display("FAIL random%0d: got %h exp %h", i, obs64, exp64);
      end
    end
  endtask

  task automatic test_xlen32();
    logic [2:0] f3s [3] = '{3'b011, 3'b110, 3'b010};
    for (int i = 0; i < 3; i++) begin
      cycle32(1'b0, 1'b1, mk_instr(5'd10, f3s[i]), 1'b1, 2'd1, 32'h100, 32'h8000_0000);
      exp32 = exp32_q.pop_front();
      obs32 = {b32.o_rd_index, b32.o_rd_data, b32.o_rd_we, b32.o_load_fault, b32.o_instret};
      checks++;
      if (obs32 !== exp32 || b32.o_load_fault !== (i < 2) ||
          (i == 2 && b32.o_rd_data !== 32'h8000_0000)) begin
        errors++; $display("FAIL xlen32_%0d: got %h exp %h", i, obs32, exp32);
      end
    end
    for (int i = 0; i < 100; i++) begin
      cycle32(($urandom_range(0, 40) == 0), ($urandom_range(0, 7) != 0),
              mk_instr(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7))), 1'($urandom),
              2'($urandom_range(0, 3)), $urandom, $urandom);
      exp32 = exp32_q.pop_front();
      obs32 = {b32.o_rd_index, b32.o_rd_data, b32.o_rd_we, b32.o_load_fault, b32.o_instret};
      checks++;
      if (obs32 !== exp32) begin
        errors++; $display("FAIL xlen32_rand%0d: got %h exp %h", i, obs32, exp32);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst64 = 1'b0; rst32 = 1'b0;
    b64.i_valid = 1'b0; b64.i_flush = 1'b0; b64.i_instruction = '0; b64.i_reg_write = 1'b0;
    b64.i_wb_sel = '0; b64.i_alu_result = '0; b64.i_mem_data = '0;
    b64.i_pc_plus4 = '0; b64.i_csr_data = '0;
    b32.i_valid = 1'b0; b32.i_flush = 1'b0; b32.i_instruction = '0; b32.i_reg_write = 1'b0;
    b32.i_wb_sel = '0; b32.i_alu_result = '0; b32.i_mem_data = '0;
    b32.i_pc_plus4 = '0; b32.i_csr_data = '0;
    m_idx = '0; m_data = '0; m_cnt = '0;
    n_idx = '0; n_data = '0; n_cnt = '0;
    test_reset();
    test_alu();
    test_load_ext();
    test_fault();
    test_x0_flush();
    test_back_to_back();
    test_wrap_and_reset();
    test_random();
    test_xlen32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
